// File: rtl/alu_pkg.sv
// alu_pkg: ALU op-code constants, legal-op bound and controller state encoding
package alu_pkg;
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_SLL = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_SRL = 4'b0100;
    localparam logic [3:0] ALU_SRA = 4'b0101;
    localparam logic [3:0] ALU_OR  = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0111;
    localparam logic [3:0] ALU_OP_LEGAL_MAX = 4'b0111;
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
endpackage

// File: rtl/alu.sv
// alu: single-cycle 32-bit ALU
//   data0, data1 : operands (shift amount = data1[4:0])
//   ctrl         : op code, undefined codes yield 0
//   result       : combinational result
//   zeroFlag     : 1 iff data0 == data1
module alu
    import alu_pkg::*;
(
    input  logic [31:0] data0,
    input  logic [31:0] data1,
    input  logic [3:0]  ctrl,
    output logic [31:0] result,
    output logic        zeroFlag
);
    always_comb begin
        result = '0;
        case (ctrl)
            ALU_ADD: result = data0 + data1;
            ALU_SUB: result = data0 - data1;
            ALU_SLL: result = data0 << data1[4:0];
            ALU_XOR: result = data0 ^ data1;
            ALU_SRL: result = data0 >> data1[4:0];
            ALU_SRA: result = $signed(data0) >>> data1[4:0];
            ALU_OR:  result = data0 | data1;
            ALU_AND: result = data0 & data1;
            default: result = '0;
        endcase
    end
    assign zeroFlag = data0 == data1;
endmodule

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: round-robin sharing of one ALU between two valid/ready requesters
//   req_valid/req_ready      : issue handshake, bit i = requester i
//   req_op*/req_a*/req_b*    : per-requester op code and operands
//   rsp_valid/rsp_ready      : response handshake to the issuing requester
//   rsp_result/zero/err      : registered response shared by both requesters
//   op_cnt                   : wrapping count of completed responses
module alu_share_ctrl
    import alu_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [3:0]       req_op0,
    input  logic [3:0]       req_op1,
    input  logic [31:0]      req_a0,
    input  logic [31:0]      req_a1,
    input  logic [31:0]      req_b0,
    input  logic [31:0]      req_b1,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [31:0]      rsp_result,
    output logic             rsp_zero,
    output logic             rsp_err,
    output logic [CNT_W-1:0] op_cnt
);
    state_t           state_q;
    logic             prio_q, owner_q, zero_q, err_q;
    logic [3:0]       op_q;
    logic [31:0]      a_q, b_q, result_q, alu_result;
    logic [1:0]       rsp_valid_q;
    logic [CNT_W-1:0] cnt_q;
    logic             grant, alu_zero, legal;
    // prio only breaks ties; a lone requester always wins
    assign grant = &req_valid ? prio_q : req_valid[1];
    assign req_ready = (!rst && state_q == IDLE && |req_valid) ? (grant ? 2'b10 : 2'b01) : 2'b00;
    assign legal = op_q <= ALU_OP_LEGAL_MAX;
    alu u_alu (
        .data0    (a_q),
        .data1    (b_q),
        .ctrl     (op_q),
        .result   (alu_result),
        .zeroFlag (alu_zero)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            prio_q      <= 1'b0;
            owner_q     <= 1'b0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            err_q       <= 1'b0;
            rsp_valid_q <= '0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                IDLE: if (|req_ready) begin
                    owner_q <= grant;
                    op_q    <= grant ? req_op1 : req_op0;
                    a_q     <= grant ? req_a1 : req_a0;
                    b_q     <= grant ? req_b1 : req_b0;
                    state_q <= EXEC;
                end
                EXEC: begin
                    // undefined op codes never leak an ALU output
                    result_q    <= legal ? alu_result : '0;
                    zero_q      <= alu_zero;
                    err_q       <= !legal;
                    rsp_valid_q <= owner_q ? 2'b10 : 2'b01;
                    state_q     <= RESP;
                end
                RESP: if (rsp_ready[owner_q]) begin
                    rsp_valid_q <= '0;
                    cnt_q       <= cnt_q + 1'b1;
                    prio_q      <= ~owner_q;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = result_q;
    assign rsp_zero   = zero_q;
    assign rsp_err    = err_q;
    assign op_cnt     = cnt_q;
endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb_alu_share_ctrl: directed and randomized checking of alu_share_ctrl against a transaction model
module tb_alu_share_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_valid = '0, rsp_ready = 2'b11;
    logic [3:0]  req_op0 = '0, req_op1 = '0;
    logic [31:0] req_a0 = '0, req_a1 = '0, req_b0 = '0, req_b1 = '0;
    logic [1:0]  req_ready, rsp_valid, rr2, rv2;
    logic [31:0] rsp_result, res2;
    logic        rsp_zero, rsp_err, z2, e2;
    logic [15:0] op_cnt;
    logic [1:0]  cnt2;
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    alu_share_ctrl dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_op0(req_op0), .req_op1(req_op1), .req_a0(req_a0), .req_a1(req_a1),
        .req_b0(req_b0), .req_b1(req_b1), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err), .op_cnt(op_cnt)
    );
    alu_share_ctrl #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rr2),
        .req_op0(req_op0), .req_op1(req_op1), .req_a0(req_a0), .req_a1(req_a1),
        .req_b0(req_b0), .req_b1(req_b1), .rsp_valid(rv2), .rsp_ready(rsp_ready),
        .rsp_result(res2), .rsp_zero(z2), .rsp_err(e2), .op_cnt(cnt2)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a << b[4:0];
            4'd3: return a ^ b;
            4'd4: return a >> b[4:0];
            4'd5: return $signed(a) >>> b[4:0];
            4'd6: return a | b;
            4'd7: return a & b;
            default: return 32'h0;
        endcase
    endfunction

    // transaction model: one op outstanding, response visible two edges after issue
    bit          busy = 0;
    int          age = 0;
    logic        exp_owner = 0, prio = 0, g, exp_zero = 0, exp_err = 0;
    logic [31:0] exp_res = '0, cnt = '0;
    logic [1:0]  exp_rv, exp_rr;

    always @(negedge clk) begin
        if (rst) begin
            busy = 0; age = 0; cnt = '0; prio = 0;
        end else begin
            if (busy) age++;
            exp_rv = (busy && age >= 2) ? (exp_owner ? 2'b10 : 2'b01) : 2'b00;
            chk("rsp_valid", rsp_valid, exp_rv);
            if (exp_rv != 0) begin
                chk("rsp_result", rsp_result, exp_res);
                chk("rsp_zero", rsp_zero, exp_zero);
                chk("rsp_err", rsp_err, exp_err);
            end
            g = (req_valid == 2'b11) ? prio : req_valid[1];
            exp_rr = (!busy && |req_valid) ? (g ? 2'b10 : 2'b01) : 2'b00;
            chk("req_ready", req_ready, exp_rr);
            chk("op_cnt", op_cnt, cnt[15:0]);
            chk("op_cnt_w2", cnt2, cnt[1:0]);
            chk("dut2_match", {rr2, rv2, res2, z2, e2}, {req_ready, rsp_valid, rsp_result, rsp_zero, rsp_err});
            if (exp_rv != 0 && rsp_ready[exp_owner]) begin
                busy = 0; cnt = cnt + 1; prio = ~exp_owner;
            end else if (exp_rr != 0) begin
                busy = 1; age = 0; exp_owner = g;
                exp_err  = (g ? req_op1 : req_op0) > 4'd7;
                exp_res  = ref_alu(g ? req_op1 : req_op0, g ? req_a1 : req_a0, g ? req_b1 : req_b0);
                exp_zero = (g ? req_a1 : req_a0) == (g ? req_b1 : req_b0);
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1; req_valid = '0; rsp_ready = 2'b11;
        repeat (2) tick();
        rst = 0;
        tick();
    endtask

    task automatic send(input int r, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        if (r == 0) begin req_op0 = op; req_a0 = a; req_b0 = b; end
        else begin req_op1 = op; req_a1 = a; req_b1 = b; end
        req_valid[r] = 1'b1;
        #1;
        while (!req_ready[r] && n < 50) begin tick(); n++; end
        if (!req_ready[r]) chk("send_timeout", 0, 1);
        tick();
        req_valid[r] = 1'b0;
    endtask

    task automatic wait_rsp(input int r, output logic [31:0] res, output logic z, output logic e);
        int n = 0;
        @(negedge clk);
        while (!rsp_valid[r] && n < 20) begin @(negedge clk); n++; end
        if (!rsp_valid[r]) chk("rsp_timeout", 0, 1);
        res = rsp_result; z = rsp_zero; e = rsp_err;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [31:0] res;
        logic        z, e;
        logic [15:0] cnt0;
        logic        grants[6];
        int          n;
        #1;
        chk("reset_state", {req_ready, rsp_valid, rsp_result, rsp_zero, rsp_err, op_cnt, cnt2}, '0);
        do_reset();
        // single ADD wraps to zero
        send(0, 4'b0000, 32'hFFFFFFFF, 32'h1);
        wait_rsp(0, res, z, e);
        chk("add_result", res, 32'h0);
        chk("add_zero", z, 0);
        chk("add_err", e, 0);
        tick();
        chk("add_cnt", op_cnt, 16'd1);
        // simultaneous requests after reset: requester 0 first
        do_reset();
        req_op0 = 4'b0001; req_a0 = 5; req_b0 = 5;
        req_op1 = 4'b0010; req_a1 = 1; req_b1 = 32'h23;
        req_valid = 2'b11;
        wait_rsp(0, res, z, e);
        req_valid[0] = 0;
        chk("sub_result", res, 32'h0);
        chk("sub_zero", z, 1);
        wait_rsp(1, res, z, e);
        req_valid[1] = 0;
        chk("sll_result", res, 32'h8);
        chk("sll_zero", z, 0);
        // fairness with both held valid
        req_op0 = 4'b0110; req_a0 = 32'h10; req_b0 = 32'h01;
        req_op1 = 4'b0111; req_a1 = 32'hFF; req_b1 = 32'h0F;
        req_valid = 2'b11;
        for (int i = 0; i < 6; i++) begin
            n = 0;
            @(negedge clk);
            while (rsp_valid == 0 && n < 20) begin @(negedge clk); n++; end
            grants[i] = rsp_valid[1];
            if (i == 5) req_valid = 2'b00;
        end
        for (int i = 0; i < 6; i++) chk($sformatf("grant_order_%0d", i), grants[i], i % 2);
        // response backpressure on requester 1
        tick();
        rsp_ready = 2'b01;
        send(1, 4'b0011, 32'hF0F0F0F0, 32'h0F0F0F0F);
        req_op0 = 4'b0000; req_a0 = 3; req_b0 = 4; req_valid[0] = 1;
        wait_rsp(1, res, z, e);
        chk("xor_result", res, 32'hFFFFFFFF);
        cnt0 = op_cnt;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", rsp_valid, 2'b10);
            chk("bp_result", rsp_result, 32'hFFFFFFFF);
            chk("bp_ready", req_ready, 2'b00);
            chk("bp_cnt", op_cnt, cnt0);
        end
        rsp_ready = 2'b11;
        tick();
        chk("bp_cnt_release", op_cnt, cnt0 + 16'd1);
        wait_rsp(0, res, z, e);
        req_valid[0] = 0;
        chk("bp_next_result", res, 32'h7);
        // illegal op
        tick();
        send(0, 4'b1010, 7, 7);
        wait_rsp(0, res, z, e);
        chk("illegal_result", res, 32'h0);
        chk("illegal_err", e, 1);
        chk("illegal_zero", z, 1);
        tick();
        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            req_op0 = 4'($urandom_range(0, 15)); req_op1 = 4'($urandom_range(0, 15));
            req_a0 = $urandom; req_a1 = $urandom;
            req_b0 = ($urandom_range(0, 3) == 0) ? req_a0 : $urandom;
            req_b1 = ($urandom_range(0, 3) == 0) ? req_a1 : $urandom;
            req_valid = 2'($urandom_range(0, 3));
            rsp_ready = 2'($urandom_range(0, 3));
            tick();
        end
        req_valid = 0; rsp_ready = 2'b11;
        repeat (5) tick();
        // reset while an op is executing
        send(1, 4'b0000, 32'd10, 32'd20);
        rst = 1;
        #1;
        chk("rst_async_outputs", {req_ready, rsp_valid, rsp_result, rsp_zero, rsp_err, op_cnt, cnt2}, '0);
        repeat (2) tick();
        rst = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rst_no_rsp", rsp_valid, 2'b00);
        end
        chk("rst_cnt", op_cnt, 16'd0);
        // counter wrap on the narrow instance
        for (int i = 0; i < 5; i++) begin
            tick();
            send(i % 2, 4'b0000, i, 1);
            wait_rsp(i % 2, res, z, e);
            chk("wrap_op_result", res, 32'(i + 1));
        end
        tick();
        chk("wrap_cnt_w2", cnt2, 2'd1);
        chk("wrap_cnt_w16", op_cnt, 16'd5);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
